// File: rtl/frame_rx_pkg.sv
// Shared constants and state encoding for the GFAS register-write frame receiver.
package frame_rx_pkg;

  localparam int ETH_HDR_LEN  = 14;
  localparam int GFAS_HDR_LEN = 6;

  localparam logic [7:0] GFAS_HDR [GFAS_HDR_LEN] = '{8'hFA, 8'hF3, 8'hDE, 8'hAD, 8'hBE, 8'hEF};

  typedef enum logic [1:0] {
    ETH  = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2,
    DROP = 2'd3
  } state_e;

endpackage

// File: rtl/frame_rx_word_pack.sv
// Big-endian byte-to-word shadow packer; the shadow is copied to the register
// file on commit, including the byte written in the same cycle.
module frame_rx_word_pack #(
  parameter int Nregs = 16,
  parameter int IDX_W = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic [IDX_W-1:0]       idx,
  input  logic [7:0]             data,
  input  logic                   commit,
  output logic                   dv,
  output logic [Nregs-1:0][31:0] wr_val
);

  logic [Nregs-1:0][31:0] shadow_q;
  logic [Nregs-1:0][31:0] shadow_d;

  // Byte 0 of a word lands in bits 31:24, so the lane is the inverted low index bits.
  always_comb begin
    shadow_d = shadow_q;
    if (we) begin
      shadow_d[idx[IDX_W-1:2]][{~idx[1:0], 3'b000} +: 8] = data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      wr_val   <= '0;
      dv       <= 1'b0;
    end else begin
      if (we) begin
        shadow_q <= shadow_d;
      end
      if (commit) begin
        wr_val <= shadow_d;
      end
      dv <= commit;
    end
  end

endmodule

// File: rtl/gfas_frame_rx.sv
// GFAS register-write frame parser on an FWFT FIFO read port.
// Optional header byte check enabled by defining FRAME_RX_HDR_CHECK_EN.
module gfas_frame_rx
  import frame_rx_pkg::*;
#(
  parameter int Nregs = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx_fifo_tvalid,
  output logic                   rx_fifo_tready,
  input  logic [7:0]             rx_fifo_tdata,
  input  logic                   rx_fifo_tlast,
  input  logic                   rx_fifo_tuser,
  output logic                   dv_out,
  output logic [Nregs-1:0][31:0] wr_val,
  output state_e                 state
);

  // Handshake: a byte transfers on every clk edge where tvalid && tready;
  // tready is low only in reset, so the parser never backpressures the FIFO.
  localparam int PAY_LEN = Nregs * 4;
  localparam int IDX_W   = $clog2(PAY_LEN);
  localparam int CNT_W   = (IDX_W > 4) ? IDX_W : 4;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             beat;
  logic             hdr_bad;
  logic             pay_we;
  logic             commit;

  assign beat  = rx_fifo_tvalid && rx_fifo_tready;
  assign state = state_q;

`ifdef FRAME_RX_HDR_CHECK_EN
  assign hdr_bad = (rx_fifo_tdata != GFAS_HDR[cnt_q[2:0]]);
`else
  assign hdr_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ETH;
      cnt_q          <= '0;
      rx_fifo_tready <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rx_fifo_tready <= 1'b1;
    end
  end

  // A tlast beat before the final payload byte always ends the frame without commit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pay_we  = 1'b0;
    commit  = 1'b0;
    if (beat) begin
      case (state_q)
        ETH: begin
          if (rx_fifo_tlast) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_W'(ETH_HDR_LEN - 1)) begin
            state_d = HDR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        HDR: begin
          cnt_d = '0;
          if (rx_fifo_tlast) begin
            state_d = ETH;
          end else if (hdr_bad) begin
            state_d = DROP;
          end else if (cnt_q == CNT_W'(GFAS_HDR_LEN - 1)) begin
            state_d = PAY;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PAY: begin
          pay_we = 1'b1;
          cnt_d  = '0;
          if (cnt_q == CNT_W'(PAY_LEN - 1)) begin
            if (!rx_fifo_tlast) begin
              state_d = DROP;
            end else begin
              state_d = ETH;
              commit  = !rx_fifo_tuser;
            end
          end else if (rx_fifo_tlast) begin
            state_d = ETH;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DROP: begin
          cnt_d = '0;
          if (rx_fifo_tlast) begin
            state_d = ETH;
          end
        end
        default: begin
          state_d = ETH;
          cnt_d   = '0;
        end
      endcase
    end
  end

  frame_rx_word_pack #(
    .Nregs (Nregs),
    .IDX_W (IDX_W)
  ) u_word_pack (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (pay_we),
    .idx    (cnt_q[IDX_W-1:0]),
    .data   (rx_fifo_tdata),
    .commit (commit),
    .dv     (dv_out),
    .wr_val (wr_val)
  );

endmodule

// File: tb/tb_gfas_frame_rx.sv
// Self-checking bench for gfas_frame_rx: directed vector table, reset sequence,
// and randomized frames scored against a frame-level reference model.
module tb_gfas_frame_rx;
  import frame_rx_pkg::*;

  localparam int NREGS     = 16;
  localparam int W         = NREGS * 32;
  localparam int PAY_LEN   = NREGS * 4;
  localparam int FRAME_LEN = 14 + 6 + PAY_LEN;
`ifdef FRAME_RX_HDR_CHECK_EN
  localparam bit HDR_CHK = 1'b1;
`else
  localparam bit HDR_CHK = 1'b0;
`endif

  logic                   clk;
  logic                   rst_n;
  logic                   rx_fifo_tvalid;
  logic                   rx_fifo_tready;
  logic [7:0]             rx_fifo_tdata;
  logic                   rx_fifo_tlast;
  logic                   rx_fifo_tuser;
  logic                   dv_out;
  logic [NREGS-1:0][31:0] wr_val;
  state_e                 state;

  gfas_frame_rx #(.Nregs(NREGS)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_fifo_tvalid (rx_fifo_tvalid),
    .rx_fifo_tready (rx_fifo_tready),
    .rx_fifo_tdata  (rx_fifo_tdata),
    .rx_fifo_tlast  (rx_fifo_tlast),
    .rx_fifo_tuser  (rx_fifo_tuser),
    .dv_out         (dv_out),
    .wr_val         (wr_val),
    .state          (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks;
  int         errors;
  int         dv_cnt;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] cur_exp;
  logic [7:0] fq[$];
  logic [7:0] hdr_ref [6] = '{8'hFA, 8'hF3, 8'hDE, 8'hAD, 8'hBE, 8'hEF};

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // scoreboard monitor: every cycle wr_val must equal the last committed frame
  always @(negedge clk) begin
    if (!rst_n) begin
      cur_exp = '0;
      chk("rst_wr_val", wr_val, '0);
      chk("rst_dv", W'(dv_out), '0);
      chk("rst_tready", W'(rx_fifo_tready), '0);
      chk("rst_state", W'(state), W'(ETH));
    end else if (dv_out) begin
      dv_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_dv: got dv_out=1 expected no commit");
      end else begin
        cur_exp = exp_q.pop_front();
        chk("commit_val", wr_val, cur_exp);
      end
    end else begin
      chk("hold_val", wr_val, cur_exp);
    end
  end

  // driver tasks
  task automatic beat(input logic [7:0] d, input logic last, input logic user);
    @(negedge clk);
    rx_fifo_tvalid = 1'b1;
    rx_fifo_tdata  = d;
    rx_fifo_tlast  = last;
    rx_fifo_tuser  = user;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_fifo_tvalid = 1'b0;
      rx_fifo_tlast  = 1'b0;
      rx_fifo_tuser  = 1'b0;
    end
  endtask

  task automatic send_frame(input logic user, input int gap_pct, input bit with_last);
    for (int i = 0; i < fq.size(); i++) begin
      if (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) idle(1);
      beat(fq[i], with_last && (i == fq.size() - 1), user && (i == fq.size() - 1));
    end
  endtask

  // frame of len bytes: Ethernet filler, correct GFAS header, incrementing payload
  task automatic build_frame(input logic [7:0] start, input int len);
    fq = {};
    for (int i = 0; i < len; i++) begin
      if (i < 14)      fq.push_back(8'(8'h80 + i));
      else if (i < 20) fq.push_back(hdr_ref[i-14]);
      else             fq.push_back(8'(start + 8'(i - 20)));
    end
  endtask

  // payload of fq laid out as the register file: word r, byte k -> bits r*32+(3-k)*8
  function automatic logic [W-1:0] payload_val();
    logic [W-1:0] v;
    v = '0;
    for (int r = 0; r < NREGS; r++)
      for (int k = 0; k < 4; k++)
        v[r*32 + (3-k)*8 +: 8] = fq[20 + 4*r + k];
    return v;
  endfunction

  // reference model: a delimited frame commits iff exact length, no MAC error, header ok
  function automatic bit model_ok(input logic user);
    bit ok;
    ok = (fq.size() == FRAME_LEN) && !user;
    if (HDR_CHK && fq.size() >= 20)
      for (int i = 0; i < 6; i++) if (fq[14+i] != hdr_ref[i]) ok = 1'b0;
    return ok;
  endfunction

  typedef struct {
    string      name;
    logic [7:0] start;
    int         len;
    logic [7:0] hdr3;
    logic       user;
    int         gap;
    bit         commit;
    logic [31:0] w0;
    logic [31:0] w15;
  } vec_t;

  vec_t tbl[10];
  logic [31:0] last_w0, last_w15;
  int          dv_before;

  initial begin
    checks = 0; errors = 0; dv_cnt = 0; cur_exp = '0;
    rst_n = 1'b0;
    rx_fifo_tvalid = 1'b0; rx_fifo_tdata = '0; rx_fifo_tlast = 1'b0; rx_fifo_tuser = 1'b0;

    tbl[0] = '{"nominal",     8'h01, 84, 8'hAD, 1'b0, 0,  1'b1,    32'h01020304, 32'h3D3E3F40};
    tbl[1] = '{"second",      8'h02, 84, 8'hAD, 1'b0, 20, 1'b1,    32'h02030405, 32'h3E3F4041};
    tbl[2] = '{"bad_hdr",     8'h05, 84, 8'hAE, 1'b0, 2,  !HDR_CHK, 32'h05060708, 32'h41424344};
    tbl[3] = '{"after_hdr",   8'h10, 84, 8'hAD, 1'b0, 0,  1'b1,    32'h10111213, 32'h4C4D4E4F};
    tbl[4] = '{"early_last",  8'h90, 61, 8'hAD, 1'b0, 1,  1'b0,    32'h0,        32'h0};
    tbl[5] = '{"after_early", 8'h20, 84, 8'hAD, 1'b0, 0,  1'b1,    32'h20212223, 32'h5C5D5E5F};
    tbl[6] = '{"tuser",       8'hA0, 84, 8'hAD, 1'b1, 0,  1'b0,    32'h0,        32'h0};
    tbl[7] = '{"after_tuser", 8'h30, 84, 8'hAD, 1'b0, 0,  1'b1,    32'h30313233, 32'h6C6D6E6F};
    tbl[8] = '{"long",        8'hB0, 87, 8'hAD, 1'b0, 3,  1'b0,    32'h0,        32'h0};
    tbl[9] = '{"after_long",  8'h40, 84, 8'hAD, 1'b0, 0,  1'b1,    32'h40414243, 32'h7C7D7E7F};

    repeat (3) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b1;
    idle(3);

    // directed vector table
    last_w0 = '0; last_w15 = '0;
    for (int i = 0; i < 10; i++) begin
      idle(tbl[i].gap);
      build_frame(tbl[i].start, tbl[i].len);
      fq[17] = tbl[i].hdr3;
      if (tbl[i].commit) begin
        exp_q.push_back(payload_val());
        last_w0  = tbl[i].w0;
        last_w15 = tbl[i].w15;
      end
      dv_before = dv_cnt;
      send_frame(tbl[i].user, 0, 1'b1);
      idle(3);
      chk({tbl[i].name, "_dv"}, W'(dv_cnt - dv_before), W'(tbl[i].commit));
      chk({tbl[i].name, "_w0"}, W'(wr_val[0]), W'(last_w0));
      chk({tbl[i].name, "_w15"}, W'(wr_val[15]), W'(last_w15));
    end

    // reset in the middle of a payload, then residue, then a good frame
    build_frame(8'h60, 50);
    send_frame(1'b0, 0, 1'b0);
    @(posedge clk); #2 rst_n = 1'b0;
    rx_fifo_tvalid = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b1;
    idle(2);
    build_frame(8'h68, 30);
    dv_before = dv_cnt;
    send_frame(1'b0, 0, 1'b1);
    idle(2);
    chk("residue_dv", W'(dv_cnt - dv_before), '0);
    chk("residue_w0", W'(wr_val[0]), '0);
    build_frame(8'h70, 84);
    exp_q.push_back(payload_val());
    send_frame(1'b0, 0, 1'b1);
    idle(3);
    chk("post_rst_dv", W'(dv_cnt - dv_before), W'(1));
    chk("post_rst_w0", W'(wr_val[0]), W'(32'h70717273));

    // randomized frames against the reference model
    for (int n = 0; n < 40; n++) begin
      int   kind;
      logic user;
      int   len;
      kind = $urandom_range(0, 4);
      user = (kind == 3);
      case (kind)
        1:       len = $urandom_range(1, FRAME_LEN - 1);
        2:       len = $urandom_range(FRAME_LEN + 1, FRAME_LEN + 16);
        default: len = FRAME_LEN;
      endcase
      build_frame(8'h00, len);
      for (int i = 20; i < len; i++) fq[i] = 8'($urandom_range(0, 255));
      if (kind == 4) begin
        int bi;
        bi = 14 + $urandom_range(0, 5);
        fq[bi] = fq[bi] ^ 8'($urandom_range(1, 255));
      end
      if (model_ok(user)) exp_q.push_back(payload_val());
      send_frame(user, ($urandom_range(0, 1) == 1) ? 20 : 0, 1'b1);
      idle($urandom_range(0, 2));
    end
    idle(5);
    chk("exp_q_drained", W'(exp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gfas_frame_rx.md
# gfas_frame_rx

Receive-side parser for GFAS register-write frames. It consumes Ethernet frames byte-by-byte from the RX MAC FIFO's AXI-Stream read side and validates a fixed 6-byte GFAS header. A valid payload of Nregs 32-bit words is committed atomically to a register file, and a one-cycle `dv_out` strobe is issued with each update. It sits between `mac_fifo` (read port, first-word-fall-through) and the register consumers in the `clk` domain.

## Interface
- `Nregs`, default 16: number of 32-bit registers. Payload length is Nregs*4 bytes.
- `clk` in 1: sole clock. The FIFO read side runs on it.
- `rst_n` in 1: reset, asynchronous and active-low.
- `rx_fifo_tvalid` in 1: FIFO not empty. Data is valid without a read (FWFT).
- `rx_fifo_tready` out 1: read enable to the FIFO. A beat transfers when tvalid && tready.
- `rx_fifo_tdata` in 8: frame byte.
- `rx_fifo_tlast` in 1: last byte of the frame.
- `rx_fifo_tuser` in 1: MAC error flag. 1 marks a bad frame; it is sampled on the tlast beat.
- `dv_out` out 1: one-cycle pulse when `wr_val` is updated.
- `wr_val` out Nregs×32, packed `[Nregs-1:0][31:0]`: register file.

## Operation
- `rx_fifo_tready` is 0 in reset and 1 at all other times. The block never stalls.
- The FSM advances only on a beat. A byte counter counts bytes within the current state.
- Frame layout: 14 Ethernet header bytes (ignored), then GFAS header FA F3 DE AD BE EF, then Nregs*4 payload bytes.
- FSM states:
  - ETH: skip 14 bytes, then go to HDR.
  - HDR: compare 6 bytes against the GFAS header. On a mismatch, go to DROP. After 6 matching bytes, go to PAY.
  - PAY: pack bytes big-endian into a shadow register. Byte 0 goes to `shadow[0][31:24]`, byte 3 to `shadow[0][7:0]`, byte 4 to `shadow[1][31:24]`, and so on.
  - PAY commit: on byte Nregs*4-1, if tlast=1 and tuser=0, copy shadow to `wr_val` and pulse `dv_out`. Then go to ETH.
  - PAY reject: if tlast=0 on the final byte, go to DROP. If tuser=1, discard the frame and go to ETH.
  - DROP: consume bytes until a tlast beat, then go to ETH.
- Early tlast, in any state before the final payload byte, ends the frame. No commit; go to ETH.
- `wr_val` changes only on a commit. A partial or rejected frame leaves `wr_val` untouched.
- Shadow contents are not cleared between frames. Each committed frame fully overwrites the shadow.

## Timing
- Reset values: `wr_val`=0, `dv_out`=0, `rx_fifo_tready`=0, state=ETH, counter=0, shadow=0.
- Throughput: one byte per clk. Back-to-back frames are accepted with zero idle beats.
- Commit latency: `wr_val` and `dv_out` update on the clk edge that accepts the final payload beat.
  - The new value is visible the following cycle.
  - `dv_out` is high for exactly one cycle, coincident with the first cycle of the new `wr_val`.
- Idle cycles (tvalid=0) inside a frame are allowed. State and counter hold.
- Reset mid-frame: immediate return to reset values. Any residue of the frame in the FIFO fails the header check and is dropped at its tlast.

## Configuration
- `FRAME_RX_HDR_CHECK_EN` defined: HDR compares each byte as above. A mismatch goes to DROP.
- `FRAME_RX_HDR_CHECK_EN` undefined: HDR skips 6 bytes unchecked. The tuser and length checks still apply.

## Structure
- Package `frame_rx_pkg`:
  - `ETH_HDR_LEN`=14
  - `GFAS_HDR_LEN`=6
  - `GFAS_HDR` as a 6-byte constant array {FA,F3,DE,AD,BE,EF}
  - state enum {ETH, HDR, PAY, DROP}
- One sub-module, `frame_rx_word_pack`: byte-to-word shadow packer with byte index input, write enable and commit output.
- The FSM and counter live in the top module.

## Test plan
- Nominal frame, payload bytes 0x01..0x40: expect one `dv_out` pulse, `wr_val[0]`=0x01020304 and `wr_val[15]`=0x3D3E3F40.
- Second frame with payload 0x02..0x41 after 20 idle cycles: expect `wr_val[0]`=0x02030405 and `wr_val[15]`=0x3E3F4041, with one pulse.
- GFAS byte 3 = 0xAE instead of 0xAD (macro defined): expect no `dv_out` and `wr_val` unchanged. The next good frame commits normally.
- tlast on payload byte 40, or tuser=1 on the final byte: expect no commit. The next frame parses correctly.
- tlast missing on byte 64, with tlast asserted 3 bytes later: expect no commit. The following frame commits.
- `rst_n` pulsed low mid-payload: expect `wr_val`=0, `dv_out`=0 and `rx_fifo_tready`=0 during reset. After release, the next complete frame commits.
